// File: rtl/adc_stream_unpacker.sv
// Rebuilds 32-bit capture words from the packed byte stream and emits the three 10-bit samples
// in capture order with trigger marking. Optional tag consistency check: ADC_UNPACK_TAGCHECK_EN.
module adc_stream_unpacker #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter logic [1:0]  TAG_IDLE  = 2'b11
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 clear_i,
  input  logic [7:0]           byte_i,
  input  logic                 byte_valid_i,
  output logic                 byte_ready_o,
  input  logic [CNT_WIDTH-1:0] max_samples_i,
  output logic [9:0]           sample_o,
  output logic                 sample_valid_o,
  input  logic                 sample_ready_i,
  output logic                 sample_trig_o,
  output logic                 trig_seen_o,
  output logic [CNT_WIDTH-1:0] trig_index_o,
  output logic [CNT_WIDTH-1:0] samples_o,
  output logic                 done_o,
  output logic                 tag_err_o
);

  typedef enum logic [1:0] {StAssemble, StEmit, StDone} state_e;

  function automatic logic [9:0] field_sel(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    field_sel = word[9:0];
      2'd1:    field_sel = word[19:10];
      default: field_sel = word[29:20];
    endcase
  endfunction

  state_e               state_q, state_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [23:0]          shift_q, shift_d;
  logic [31:0]          word_q, word_d;
  logic [1:0]           idx_q, idx_d;
  logic [CNT_WIDTH-1:0] samples_q, samples_d;
  logic                 trig_seen_q, trig_seen_d;
  logic [CNT_WIDTH-1:0] trig_index_q, trig_index_d;
  logic                 done_q, done_d;
  logic                 sample_valid_q, sample_valid_d;
  logic [9:0]           sample_q, sample_d;
  logic                 sample_trig_q, sample_trig_d;
  logic                 byte_ready_q, byte_ready_d;
  logic                 trig_word_q, trig_word_d;
`ifdef ADC_UNPACK_TAGCHECK_EN
  logic [1:0]           tag_ref_q, tag_ref_d;
  logic                 tag_err_q, tag_err_d;
`endif

  logic [31:0]          new_word;
  logic [1:0]           new_tag;
  logic                 new_trig;
  logic [1:0]           idx_next;
  logic [CNT_WIDTH-1:0] samples_inc;
  logic                 byte_accept;
  logic                 sample_accept;
  logic                 hit_max;

  // Clear wins over everything, so a byte offered in the clear cycle must be refused.
  assign byte_ready_o  = byte_ready_q & ~clear_i;
  assign byte_accept   = byte_valid_i & byte_ready_o;
  assign sample_accept = sample_valid_q & sample_ready_i;

  assign new_word    = {shift_q, byte_i};
  assign new_tag     = new_word[31:30];
  assign new_trig    = (new_tag != TAG_IDLE) && !trig_seen_q;
  assign idx_next    = idx_q + 2'd1;
  assign samples_inc = samples_q + CNT_WIDTH'(1);
  assign hit_max     = (max_samples_i != '0) && (samples_inc == max_samples_i);

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    shift_d        = shift_q;
    word_d         = word_q;
    idx_d          = idx_q;
    samples_d      = samples_q;
    trig_seen_d    = trig_seen_q;
    trig_index_d   = trig_index_q;
    done_d         = done_q;
    sample_valid_d = sample_valid_q;
    sample_d       = sample_q;
    sample_trig_d  = sample_trig_q;
    byte_ready_d   = byte_ready_q;
    trig_word_d    = trig_word_q;
`ifdef ADC_UNPACK_TAGCHECK_EN
    tag_ref_d      = tag_ref_q;
    tag_err_d      = tag_err_q;
`endif

    if (clear_i) begin
      state_d        = StAssemble;
      byte_cnt_d     = 2'd0;
      idx_d          = 2'd0;
      samples_d      = '0;
      trig_seen_d    = 1'b0;
      trig_index_d   = '0;
      done_d         = 1'b0;
      sample_valid_d = 1'b0;
      sample_trig_d  = 1'b0;
      byte_ready_d   = 1'b1;
      trig_word_d    = 1'b0;
`ifdef ADC_UNPACK_TAGCHECK_EN
      tag_err_d      = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StAssemble: begin
          byte_ready_d = 1'b1;
          if (byte_accept) begin
            shift_d    = new_word[23:0];
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              word_d         = new_word;
              idx_d          = 2'd0;
              state_d        = StEmit;
              byte_ready_d   = 1'b0;
              sample_valid_d = 1'b1;
              sample_d       = new_word[9:0];
              trig_word_d    = new_trig;
              sample_trig_d  = new_trig && (new_tag == 2'd0);
`ifdef ADC_UNPACK_TAGCHECK_EN
              if (trig_seen_q && (new_tag != tag_ref_q)) begin
                tag_err_d = 1'b1;
              end
              if (new_trig) begin
                tag_ref_d = new_tag;
              end
`endif
            end
          end
        end

        StEmit: begin
          byte_ready_d = 1'b0;
          if (sample_accept) begin
            samples_d = samples_inc;
            idx_d     = idx_next;
            if (sample_trig_q) begin
              trig_seen_d  = 1'b1;
              trig_index_d = samples_q;
            end
            // Reaching the sample limit drops the rest of the word, trigger sample included.
            if (hit_max) begin
              state_d        = StDone;
              done_d         = 1'b1;
              sample_valid_d = 1'b0;
              sample_trig_d  = 1'b0;
            end else if (idx_q == 2'd2) begin
              state_d        = StAssemble;
              sample_valid_d = 1'b0;
              sample_trig_d  = 1'b0;
              byte_ready_d   = 1'b1;
            end else begin
              sample_d      = field_sel(word_q, idx_next);
              sample_trig_d = trig_word_q && (word_q[31:30] == idx_next);
            end
          end
        end

        StDone: begin
          byte_ready_d   = 1'b0;
          sample_valid_d = 1'b0;
          sample_trig_d  = 1'b0;
        end

        default: begin
          state_d = StAssemble;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q        <= StAssemble;
      byte_cnt_q     <= 2'd0;
      shift_q        <= '0;
      word_q         <= '0;
      idx_q          <= 2'd0;
      samples_q      <= '0;
      trig_seen_q    <= 1'b0;
      trig_index_q   <= '0;
      done_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_q       <= '0;
      sample_trig_q  <= 1'b0;
      byte_ready_q   <= 1'b0;
      trig_word_q    <= 1'b0;
`ifdef ADC_UNPACK_TAGCHECK_EN
      tag_ref_q      <= 2'd0;
      tag_err_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      shift_q        <= shift_d;
      word_q         <= word_d;
      idx_q          <= idx_d;
      samples_q      <= samples_d;
      trig_seen_q    <= trig_seen_d;
      trig_index_q   <= trig_index_d;
      done_q         <= done_d;
      sample_valid_q <= sample_valid_d;
      sample_q       <= sample_d;
      sample_trig_q  <= sample_trig_d;
      byte_ready_q   <= byte_ready_d;
      trig_word_q    <= trig_word_d;
`ifdef ADC_UNPACK_TAGCHECK_EN
      tag_ref_q      <= tag_ref_d;
      tag_err_q      <= tag_err_d;
`endif
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = sample_valid_q;
  assign sample_trig_o  = sample_trig_q;
  assign trig_seen_o    = trig_seen_q;
  assign trig_index_o   = trig_index_q;
  assign samples_o      = samples_q;
  assign done_o         = done_q;
`ifdef ADC_UNPACK_TAGCHECK_EN
  assign tag_err_o      = tag_err_q;
`else
  assign tag_err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_adc_stream_unpacker.sv
// Randomized bench for adc_stream_unpacker; expected samples come from a word-list model.
module tb_adc_stream_unpacker;

  localparam int unsigned CNT_WIDTH = 32;

  logic                 clk_i = 1'b0;
  logic                 reset_n_i;
  logic                 clear_i;
  logic [7:0]           byte_i;
  logic                 byte_valid_i;
  logic                 byte_ready_o;
  logic [CNT_WIDTH-1:0] max_samples_i;
  logic [9:0]           sample_o;
  logic                 sample_valid_o;
  logic                 sample_ready_i;
  logic                 sample_trig_o;
  logic                 trig_seen_o;
  logic [CNT_WIDTH-1:0] trig_index_o;
  logic [CNT_WIDTH-1:0] samples_o;
  logic                 done_o;
  logic                 tag_err_o;

  always #5 clk_i = ~clk_i;

  adc_stream_unpacker #(
    .CNT_WIDTH (CNT_WIDTH),
    .TAG_IDLE  (2'b11)
  ) u_dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .clear_i        (clear_i),
    .byte_i         (byte_i),
    .byte_valid_i   (byte_valid_i),
    .byte_ready_o   (byte_ready_o),
    .max_samples_i  (max_samples_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .sample_ready_i (sample_ready_i),
    .sample_trig_o  (sample_trig_o),
    .trig_seen_o    (trig_seen_o),
    .trig_index_o   (trig_index_o),
    .samples_o      (samples_o),
    .done_o         (done_o),
    .tag_err_o      (tag_err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model state for the current scenario.
  logic [31:0] words_q[$];
  logic [9:0]  exp_s_q[$];
  logic        exp_t_q[$];
  int          exp_n;
  int          n_send;
  logic        exp_seen;
  logic [31:0] exp_tidx;
  logic        exp_done;
  logic        exp_err;

  task automatic compute_model(input int max);
    int   total;
    int   trig_at;
    int   fw;
    logic [1:0] tag_ref;
    total    = 3 * words_q.size();
    exp_done = (max != 0) && (max <= total);
    exp_n    = exp_done ? max : total;
    n_send   = exp_done ? (max + 2) / 3 : words_q.size();
    trig_at  = -1;
    fw       = words_q.size();
    tag_ref  = 2'd0;
    for (int w = 0; w < words_q.size(); w++) begin
      if (words_q[w][31:30] != 2'b11) begin
        tag_ref = words_q[w][31:30];
        trig_at = 3 * w + int'(tag_ref);
        fw      = w;
        break;
      end
    end
    exp_s_q.delete();
    exp_t_q.delete();
    for (int k = 0; k < exp_n; k++) begin
      exp_s_q.push_back(10'((words_q[k / 3] >> (10 * (k % 3))) & 32'h3FF));
      exp_t_q.push_back(k == trig_at);
    end
    exp_seen = (trig_at >= 0) && (trig_at < exp_n);
    exp_tidx = exp_seen ? 32'(trig_at) : 32'd0;
    exp_err  = 1'b0;
`ifdef ADC_UNPACK_TAGCHECK_EN
    for (int w = fw + 1; w < n_send; w++) begin
      if (words_q[w][31:30] != tag_ref) exp_err = 1'b1;
    end
`endif
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic taken = 1'b0;
    int   t     = 0;
    while (!taken && t < 500) begin
      @(negedge clk_i);
      t++;
      if ($urandom_range(3) == 0) begin
        byte_valid_i = 1'b0;
        byte_i       = 8'($urandom);
      end else begin
        byte_valid_i = 1'b1;
        byte_i       = b;
        taken        = byte_ready_o;
      end
    end
    check("byte_accept", {31'd0, taken}, 32'd1);
  endtask

  task automatic drive_bytes(input int nw);
    for (int w = 0; w < nw; w++) begin
      for (int b = 3; b >= 0; b--) send_byte(words_q[w][8*b +: 8]);
    end
    @(negedge clk_i);
    byte_valid_i = 1'b0;
  endtask

  task automatic consume(input int n, input int pct, input logic [9:0] stall_val);
    int         got    = 0;
    int         cyc    = 0;
    int         stall  = 0;
    logic       held_v = 1'b0;
    logic [9:0] held_s = '0;
    logic       held_t = 1'b0;
    while (got < n && cyc < 5000) begin
      @(negedge clk_i);
      cyc++;
      if (held_v) check("hold_valid", {31'd0, sample_valid_o}, 32'd1);
      if (sample_valid_o) begin
        check("no_byte_in_emit", {31'd0, byte_ready_o}, 32'd0);
        if (held_v) begin
          check("hold_sample", {22'd0, sample_o}, {22'd0, held_s});
          check("hold_trig", {31'd0, sample_trig_o}, {31'd0, held_t});
        end
        if (sample_o == stall_val && stall < 5) begin
          sample_ready_i = 1'b0;
          stall++;
        end else begin
          sample_ready_i = ($urandom_range(99) < pct);
        end
        if (sample_ready_i) begin
          check("sample", {22'd0, sample_o}, {22'd0, exp_s_q[got]});
          check("sample_trig", {31'd0, sample_trig_o}, {31'd0, exp_t_q[got]});
          got++;
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held_s = sample_o;
          held_t = sample_trig_o;
        end
      end else begin
        sample_ready_i = 1'($urandom_range(1));
        held_v         = 1'b0;
      end
    end
    check("sample_count", 32'(got), 32'(n));
    @(negedge clk_i);
    sample_ready_i = 1'b1;
  endtask

  task automatic run_scenario(input int max, input int pct, input logic [9:0] stall_val);
    compute_model(max);
    max_samples_i = 32'(max);
    fork
      drive_bytes(n_send);
      consume(exp_n, pct, stall_val);
    join
    repeat (3) @(negedge clk_i);
    check("samples_o", samples_o, 32'(exp_n));
    check("trig_seen", {31'd0, trig_seen_o}, {31'd0, exp_seen});
    check("trig_index", trig_index_o, exp_tidx);
    check("done", {31'd0, done_o}, {31'd0, exp_done});
    check("tag_err", {31'd0, tag_err_o}, {31'd0, exp_err});
    check("idle_valid", {31'd0, sample_valid_o}, 32'd0);
    check("idle_byte_ready", {31'd0, byte_ready_o}, {31'd0, !exp_done});
  endtask

  task automatic clear_pulse();
    @(negedge clk_i);
    clear_i      = 1'b1;
    byte_valid_i = 1'b1;
    byte_i       = 8'hFF;
    #1;
    check("clear_blocks_byte", {31'd0, byte_ready_o}, 32'd0);
    @(negedge clk_i);
    clear_i      = 1'b0;
    byte_valid_i = 1'b0;
    #1;
    check("clear_valid", {31'd0, sample_valid_o}, 32'd0);
    check("clear_samples", samples_o, 32'd0);
    check("clear_done", {31'd0, done_o}, 32'd0);
    check("clear_trig_seen", {31'd0, trig_seen_o}, 32'd0);
    check("clear_byte_ready", {31'd0, byte_ready_o}, 32'd1);
  endtask

  initial begin
    reset_n_i      = 1'b0;
    clear_i        = 1'b0;
    byte_i         = 8'h00;
    byte_valid_i   = 1'b0;
    sample_ready_i = 1'b0;
    max_samples_i  = '0;
    repeat (2) @(negedge clk_i);
    check("rst_byte_ready", {31'd0, byte_ready_o}, 32'd0);
    check("rst_valid", {31'd0, sample_valid_o}, 32'd0);
    check("rst_sample", {22'd0, sample_o}, 32'd0);
    check("rst_samples", samples_o, 32'd0);
    check("rst_trig_seen", {31'd0, trig_seen_o}, 32'd0);
    check("rst_trig_index", trig_index_o, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_tag_err", {31'd0, tag_err_o}, 32'd0);
    reset_n_i = 1'b1;
    #1;
    check("release_byte_ready", {31'd0, byte_ready_o}, 32'd0);
    @(negedge clk_i);
    check("first_edge_byte_ready", {31'd0, byte_ready_o}, 32'd1);

    // Basic decode.
    words_q = '{32'hD55AA801};
    run_scenario(0, 100, 10'h3FF);

    // Trigger in the second word.
    clear_pulse();
    words_q = '{32'hD55AA801, 32'h43008010};
    run_scenario(0, 100, 10'h3FF);

    // Backpressure held on 0x2AA.
    clear_pulse();
    words_q = '{32'hD55AA801};
    run_scenario(0, 100, 10'h2AA);

    // Sample limit cuts the trigger word.
    clear_pulse();
    words_q = '{32'hD55AA801, 32'h43008010};
    run_scenario(4, 70, 10'h3FF);

    // Clear in the middle of a partial word.
    clear_pulse();
    max_samples_i = '0;
    words_q = '{32'hD55AA801};
    send_byte(8'hD5);
    send_byte(8'h5A);
    clear_pulse();
    words_q = '{32'h43008010};
    run_scenario(0, 100, 10'h3FF);

    // Inconsistent tag after the trigger.
    clear_pulse();
    words_q = '{32'h43008010, 32'h83008010};
    run_scenario(0, 80, 10'h3FF);

    for (int it = 0; it < 10; it++) begin
      int nw;
      int max;
      clear_pulse();
      nw = $urandom_range(1, 6);
      words_q.delete();
      for (int w = 0; w < nw; w++) begin
        logic [1:0] tag;
        tag = ($urandom_range(1) == 0) ? 2'b11 : 2'($urandom_range(3));
        words_q.push_back({tag, 30'($urandom)});
      end
      max = ($urandom_range(3) == 0) ? 0 : $urandom_range(1, 3 * nw + 2);
      run_scenario(max, $urandom_range(30, 100), 10'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
